ahb_lite_sram_subordinate: RTL and testbench

AHB-Lite subordinate memory that sits directly downstream of the DMA engine's manager port, giving the DMA a local transfer target in standalone and co-simulated benches. It decodes one address window, stores data in a word-organised register array with little-endian byte lanes, inserts programmable wait states, and returns a two-cycle ERROR response for illegal accesses. Write-to-read hazards between back-to-back transfers are handled so every read returns the most recently written data.

---
 rtl/ahb_lite_sram_subordinate.sv | 217 +++++++++++++++++++++
 tb/tb_ahb_lite_sram_subordinate.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_subordinate.sv
// AHB-Lite subordinate SRAM model: one address window, word-organised storage,
// little-endian byte lanes, programmable wait states, two-cycle ERROR response.
// Optional feature macro: AHB_SRAM_RAW_FORWARD_EN. When defined, a read that
// hits the word being written in the same cycle is served by merging the write
// lanes into hrdata. When undefined, that read takes one extra wait state.
module ahb_lite_sram_subordinate #(
   parameter int                      AddressWidth = 32,
   parameter int                      DataWidth    = 32,
   parameter int                      DepthWords   = 1024,
   parameter logic [AddressWidth-1:0] BaseAddress  = {AddressWidth{1'b0}},
   parameter int                      WaitStates   = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    hsel,
   input  logic [AddressWidth-1:0] haddr,
   input  logic [1:0]              htrans,
   input  logic                    hwrite,
   input  logic [2:0]              hsize,
   input  logic [2:0]              hburst,
   input  logic [DataWidth-1:0]    hwdata,
   input  logic                    hready,
   output logic                    hreadyout,
   output logic                    hresp,
   output logic [DataWidth-1:0]    hrdata
);

   localparam int                BYTES     = DataWidth / 8;
   localparam int                LANE_BITS = $clog2(BYTES);
   localparam int                IDX_W     = $clog2(DepthWords);
   localparam int                AW1       = AddressWidth + 1;
   localparam logic [AW1-1:0]    WIN_BYTES = AW1'(DepthWords * BYTES);
   localparam logic [2:0]        MAX_SIZE  = 3'(LANE_BITS);
   localparam logic [3:0]        WS        = 4'(WaitStates);
   localparam logic [AddressWidth-1:0] ONE_A = {{(AddressWidth-1){1'b0}}, 1'b1};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ERR1 = 2'd2;
   localparam logic [1:0] S_ERR2 = 2'd3;

   logic [DataWidth-1:0]    r_mem [DepthWords];
   logic [1:0]              r_state;
   logic [3:0]              r_cnt;
   logic                    r_wr_pend;
   logic                    r_rd_pend;
   logic [IDX_W-1:0]        r_idx;
   logic [BYTES-1:0]        r_be;
   logic [DataWidth-1:0]    r_hrdata;
   logic                    r_hreadyout;
   logic                    r_hresp;

   logic [1:0]              w_next_state;
   logic [AddressWidth-1:0] w_off;
   logic [AddressWidth-1:0] w_align_mask;
   logic [IDX_W-1:0]        w_idx;
   logic [BYTES-1:0]        w_size_mask;
   logic [BYTES-1:0]        w_be;
   logic [DataWidth-1:0]    w_rd_word;
   logic                    w_take;
   logic                    w_err;
   logic                    w_commit;
   logic                    w_raw;
   logic                    w_stall;
   logic                    w_go_wait;
   logic                    w_unused;

   assign w_off    = haddr - BaseAddress;
   assign w_idx    = w_off[LANE_BITS +: IDX_W];
   // A new address phase is only taken while this subordinate is ready (IDLE or ERR2).
   assign w_take   = hsel & hready & htrans[1] & ((r_state == S_IDLE) | (r_state == S_ERR2));
   // A pending write lands at the edge that ends its ready data-phase cycle.
   assign w_commit = r_wr_pend & (r_state == S_IDLE);
   assign w_raw    = w_take & ~w_err & ~hwrite & w_commit & (w_idx == r_idx);
   // Burst type and the BUSY/IDLE distinction carry no meaning here.
   assign w_unused = ^{hburst, htrans[0]};

   assign hreadyout = r_hreadyout;
   assign hresp     = r_hresp;
   assign hrdata    = r_hrdata;

   // Legality checks on the address phase: window, size and alignment.
   always_comb begin
      w_align_mask = (ONE_A << hsize) - ONE_A;
      w_err        = 1'b0;
      if (haddr < BaseAddress) begin
         w_err = 1'b1;
      end else if ({1'b0, w_off} >= WIN_BYTES) begin
         w_err = 1'b1;
      end else if (hsize > MAX_SIZE) begin
         w_err = 1'b1;
      end else if ((haddr & w_align_mask) != {AddressWidth{1'b0}}) begin
         w_err = 1'b1;
      end else begin
         w_err = 1'b0;
      end
   end

   // Byte-lane enables from transfer size and low address bits (little-endian).
   always_comb begin
      w_size_mask = {BYTES{1'b0}};
      for (int i = 0; i < BYTES; i++) begin
         if ($unsigned(i) < (32'd1 << hsize)) begin
            w_size_mask[i] = 1'b1;
         end else begin
            w_size_mask[i] = 1'b0;
         end
      end
      w_be = w_size_mask << haddr[LANE_BITS-1:0];
   end

   // Zero-wait read data, with same-cycle write data merged when forwarding is built in.
   always_comb begin
      w_rd_word = r_mem[w_idx];
`ifdef AHB_SRAM_RAW_FORWARD_EN
      w_stall = 1'b0;
      for (int b = 0; b < BYTES; b++) begin
         if (w_raw && r_be[b]) begin
            w_rd_word[b*8 +: 8] = hwdata[b*8 +: 8];
         end else begin
            w_rd_word[b*8 +: 8] = r_mem[w_idx][b*8 +: 8];
         end
      end
`else
      w_stall = w_raw;
`endif
      w_go_wait = (WS != 4'd0) | w_stall;
   end

   // Next-state decision for the data-phase controller.
   always_comb begin
      w_next_state = S_IDLE;
      case (r_state)
         S_IDLE, S_ERR2: begin
            if (w_take && w_err) begin
               w_next_state = S_ERR1;
            end else if (w_take && w_go_wait) begin
               w_next_state = S_WAIT;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_next_state = S_IDLE;
            end else begin
               w_next_state = S_WAIT;
            end
         end
         S_ERR1:  w_next_state = S_ERR2;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Controller state, response outputs, wait counter and captured transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_hreadyout <= 1'b1;
         r_hresp     <= 1'b0;
         r_cnt       <= 4'd0;
         r_wr_pend   <= 1'b0;
         r_rd_pend   <= 1'b0;
         r_idx       <= {IDX_W{1'b0}};
         r_be        <= {BYTES{1'b0}};
         r_hrdata    <= {DataWidth{1'b0}};
      end else begin
         r_state     <= w_next_state;
         r_hreadyout <= (w_next_state == S_IDLE) | (w_next_state == S_ERR2);
         r_hresp     <= (w_next_state == S_ERR1) | (w_next_state == S_ERR2);
         case (r_state)
            S_IDLE, S_ERR2: begin
               r_wr_pend <= w_take & ~w_err & hwrite;
               r_rd_pend <= w_take & ~w_err & ~hwrite;
               if (w_take) begin
                  r_idx <= w_idx;
                  r_be  <= w_be;
               end
               // Counter holds the number of remaining WAIT cycles minus one.
               if (w_take && !w_err) begin
                  r_cnt <= w_stall ? WS : (WS - 4'd1);
               end else begin
                  r_cnt <= 4'd0;
               end
               if (w_take && !w_err && !hwrite && !w_go_wait) begin
                  r_hrdata <= w_rd_word;
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  if (r_rd_pend) begin
                     r_hrdata <= r_mem[r_idx];
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
               r_wr_pend <= 1'b0;
               r_rd_pend <= 1'b0;
            end
         endcase
      end
   end

   // Storage array: not reset; only enabled lanes of a completing write change.
   always_ff @(posedge clk) begin
      if (w_commit) begin
         for (int b = 0; b < BYTES; b++) begin
            if (r_be[b]) begin
               r_mem[r_idx][b*8 +: 8] <= hwdata[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_ahb_lite_sram_subordinate.sv
// Self-checking bench: instance 0 has no wait states, instance 1 has three.
// Table vectors, hand-written corner sequences and a randomized run against a
// byte-level memory model.
module tb_ahb_lite_sram_subordinate;

   localparam int RAW_STALL =
`ifdef AHB_SRAM_RAW_FORWARD_EN
      0;
`else
      1;
`endif

   logic clk = 1'b0;
   logic rst;
   logic [1:0]       hsel;
   logic [1:0][31:0] haddr;
   logic [1:0][1:0]  htrans;
   logic [1:0]       hwrite;
   logic [1:0][2:0]  hsize;
   logic [1:0][2:0]  hburst;
   logic [1:0][31:0] hwdata;
   logic             rdy0, rdy1, resp0, resp1;
   logic [31:0]      rdata0, rdata1;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      bit          exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t        vecs[$];
   logic [7:0]  ref_mem [2][64];

   ahb_lite_sram_subordinate #(.WaitStates(0)) dut0 (
      .clk(clk), .rst(rst), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
      .hwrite(hwrite[0]), .hsize(hsize[0]), .hburst(hburst[0]), .hwdata(hwdata[0]),
      .hready(rdy0), .hreadyout(rdy0), .hresp(resp0), .hrdata(rdata0));

   ahb_lite_sram_subordinate #(.WaitStates(3)) dut1 (
      .clk(clk), .rst(rst), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
      .hwrite(hwrite[1]), .hsize(hsize[1]), .hburst(hburst[1]), .hwdata(hwdata[1]),
      .hready(rdy1), .hreadyout(rdy1), .hresp(resp1), .hrdata(rdata1));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic get_rdy(input int d);
      return (d == 0) ? rdy0 : rdy1;
   endfunction

   function automatic logic get_resp(input int d);
      return (d == 0) ? resp0 : resp1;
   endfunction

   function automatic logic [31:0] get_rdata(input int d);
      return (d == 0) ? rdata0 : rdata1;
   endfunction

   function automatic logic [31:0] lane_mask(input logic [31:0] addr, input logic [2:0] size);
      logic [31:0] m = 32'd0;
      for (int i = 0; i < (1 << size); i++) begin
         m[8*((int'(addr[1:0]) + i) % 4) +: 8] = 8'hFF;
      end
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic bus_idle(input int d);
      hsel[d]   = 1'b0;
      htrans[d] = 2'b00;
      hwrite[d] = 1'b0;
   endtask

   // One non-pipelined transfer; called at #1 after a rising edge with the bus ready.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output bit resp_done, output bit low_resp, output int waits);
      hsel[d] = 1'b1; haddr[d] = addr; htrans[d] = 2'b10; hwrite[d] = wr;
      hsize[d] = size; hburst[d] = 3'd0;
      @(posedge clk); #1;
      bus_idle(d);
      hwdata[d] = wdata;
      waits = 0; low_resp = 1'b1;
      while (!get_rdy(d) && waits < 40) begin
         low_resp = low_resp & get_resp(d);
         @(posedge clk); #1;
         waits++;
      end
      check("hreadyout returns", {31'd0, get_rdy(d)}, 32'd1);
      rdata     = get_rdata(d);
      resp_done = get_resp(d);
      @(posedge clk); #1;
   endtask

   function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata, input bit err, input logic [31:0] exp);
      vec_t v;
      v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata; v.exp_err = err; v.exp_rdata = exp;
      return v;
   endfunction

   initial begin
      logic [31:0] rd, expw, m, a32;
      bit          rsp, lowr, err, wr;
      int          w, ws, sz, a;

      hsel = '0; haddr = '0; htrans = '0; hwrite = '0; hsize = '0; hburst = '0; hwdata = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset hreadyout0", {31'd0, rdy0}, 32'd1);
      check("reset hresp0",     {31'd0, resp0}, 32'd0);
      check("reset hrdata0",    rdata0, 32'd0);
      check("reset hreadyout1", {31'd0, rdy1}, 32'd1);
      check("reset hresp1",     {31'd0, resp1}, 32'd0);
      check("reset hrdata1",    rdata1, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // ---- table-driven vectors on the zero-wait instance ----
      vecs.push_back(mk(1'b1, 32'h10,  3'd2, 32'hDEAD_BEEF, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 32'h10,  3'd2, 32'h0,         1'b0, 32'hDEAD_BEEF));
      vecs.push_back(mk(1'b1, 32'h10,  3'd2, 32'h1111_1111, 1'b0, 32'h0));
      vecs.push_back(mk(1'b1, 32'h13,  3'd0, 32'hA5CC_CCCC, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 32'h10,  3'd2, 32'h0,         1'b0, 32'hA511_1111));
      vecs.push_back(mk(1'b1, 32'h00,  3'd2, 32'hCAFE_F00D, 1'b0, 32'h0));
      vecs.push_back(mk(1'b1, 32'h1000,3'd2, 32'h0BAD_BAD0, 1'b1, 32'h0));
      vecs.push_back(mk(1'b0, 32'h1000,3'd2, 32'h0,         1'b1, 32'h0));
      vecs.push_back(mk(1'b1, 32'h01,  3'd1, 32'hFFFF_FFFF, 1'b1, 32'h0));
      vecs.push_back(mk(1'b0, 32'h01,  3'd1, 32'h0,         1'b1, 32'h0));
      vecs.push_back(mk(1'b1, 32'h02,  3'd2, 32'hEEEE_EEEE, 1'b1, 32'h0));
      vecs.push_back(mk(1'b0, 32'h00,  3'd3, 32'h0,         1'b1, 32'h0));
      vecs.push_back(mk(1'b0, 32'h00,  3'd2, 32'h0,         1'b0, 32'hCAFE_F00D));
      vecs.push_back(mk(1'b1, 32'h04,  3'd2, 32'h0123_4567, 1'b0, 32'h0));
      vecs.push_back(mk(1'b1, 32'h06,  3'd1, 32'hBEEF_9999, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 32'h06,  3'd1, 32'h0,         1'b0, 32'hBEEF_0000));
      vecs.push_back(mk(1'b0, 32'h04,  3'd2, 32'h0,         1'b0, 32'hBEEF_4567));
      vecs.push_back(mk(1'b1, 32'hFFC, 3'd2, 32'h7777_0001, 1'b0, 32'h0));
      vecs.push_back(mk(1'b1, 32'hFFE, 3'd1, 32'h5A5A_0000, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 32'hFFC, 3'd2, 32'h0,         1'b0, 32'h5A5A_0001));
      vecs.push_back(mk(1'b0, 32'h00,  3'd2, 32'h0,         1'b0, 32'hCAFE_F00D));

      foreach (vecs[k]) begin
         xfer(0, vecs[k].wr, vecs[k].addr, vecs[k].size, vecs[k].wdata, rd, rsp, lowr, w);
         check($sformatf("vec%0d hresp", k), {31'd0, rsp}, {31'd0, vecs[k].exp_err});
         check($sformatf("vec%0d waits", k), w, vecs[k].exp_err ? 32'd1 : 32'd0);
         if (vecs[k].exp_err) begin
            check($sformatf("vec%0d err low-phase hresp", k), {31'd0, lowr}, 32'd1);
         end else if (!vecs[k].wr) begin
            m = lane_mask(vecs[k].addr, vecs[k].size);
            check($sformatf("vec%0d rdata", k), rd & m, vecs[k].exp_rdata & m);
         end
      end

      // ---- back-to-back write then read of the same word ----
      hsel[0] = 1'b1; haddr[0] = 32'h20; htrans[0] = 2'b10; hwrite[0] = 1'b1; hsize[0] = 3'd2;
      @(posedge clk); #1;
      hwdata[0] = 32'h1234_5678;
      hwrite[0] = 1'b0;
      @(posedge clk); #1;
      bus_idle(0);
      w = 0;
      while (!rdy0 && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      check("b2b extra cycles", w, RAW_STALL);
      check("b2b rdata", rdata0, 32'h1234_5678);
      check("b2b hresp", {31'd0, resp0}, 32'd0);
      @(posedge clk); #1;

      // ---- new transfer taken during the second ERROR cycle ----
      hsel[0] = 1'b1; haddr[0] = 32'h1000; htrans[0] = 2'b10; hwrite[0] = 1'b0; hsize[0] = 3'd2;
      @(posedge clk); #1;
      bus_idle(0);
      check("err1 hreadyout", {31'd0, rdy0}, 32'd0);
      check("err1 hresp", {31'd0, resp0}, 32'd1);
      @(posedge clk); #1;
      check("err2 hreadyout", {31'd0, rdy0}, 32'd1);
      check("err2 hresp", {31'd0, resp0}, 32'd1);
      hsel[0] = 1'b1; haddr[0] = 32'h00; htrans[0] = 2'b10; hwrite[0] = 1'b0; hsize[0] = 3'd2;
      @(posedge clk); #1;
      bus_idle(0);
      check("after err2 hreadyout", {31'd0, rdy0}, 32'd1);
      check("after err2 hresp", {31'd0, resp0}, 32'd0);
      check("after err2 rdata", rdata0, 32'hCAFE_F00D);
      @(posedge clk); #1;

      // ---- three wait states ----
      xfer(1, 1'b1, 32'h40, 3'd2, 32'h55AA_33CC, rd, rsp, lowr, w);
      check("ws3 write waits", w, 32'd3);
      xfer(1, 1'b0, 32'h40, 3'd2, 32'h0, rd, rsp, lowr, w);
      check("ws3 read waits", w, 32'd3);
      check("ws3 read rdata", rd, 32'h55AA_33CC);
      check("ws3 read hresp", {31'd0, rsp}, 32'd0);

      // ---- reset while a write is stalled ----
      xfer(1, 1'b1, 32'h50, 3'd2, 32'h600D_F00D, rd, rsp, lowr, w);
      hsel[1] = 1'b1; haddr[1] = 32'h50; htrans[1] = 2'b10; hwrite[1] = 1'b1; hsize[1] = 3'd2;
      @(posedge clk); #1;
      bus_idle(1);
      hwdata[1] = 32'hBAD0_0BAD;
      check("stalled write hreadyout", {31'd0, rdy1}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("mid reset hreadyout", {31'd0, rdy1}, 32'd1);
      check("mid reset hresp", {31'd0, resp1}, 32'd0);
      check("mid reset hrdata", rdata1, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      xfer(1, 1'b0, 32'h50, 3'd2, 32'h0, rd, rsp, lowr, w);
      check("after reset rdata", rd, 32'h600D_F00D);

      // ---- randomized run against a byte-level model ----
      for (int d = 0; d < 2; d++) begin
         ws = (d == 0) ? 0 : 3;
         for (int k = 0; k < 16; k++) begin
            expw = $urandom;
            xfer(d, 1'b1, 32'(k * 4), 3'd2, expw, rd, rsp, lowr, w);
            for (int b = 0; b < 4; b++) ref_mem[d][k*4 + b] = expw[8*b +: 8];
         end
         for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 9) == 0) a32 = 32'h1000 + 32'($urandom_range(0, 255));
            else a32 = 32'($urandom_range(0, 63));
            sz   = $urandom_range(0, 3);
            wr   = 1'($urandom_range(0, 1));
            expw = $urandom;
            err  = (a32 >= 32'd4096) || (sz > 2) || ((a32 % (32'd1 << sz)) != 32'd0);
            xfer(d, wr, a32, 3'(sz), expw, rd, rsp, lowr, w);
            check("rand hresp", {31'd0, rsp}, {31'd0, err});
            check("rand waits", w, err ? 32'd1 : 32'(ws));
            if (!err && wr) begin
               for (int i = 0; i < (1 << sz); i++) begin
                  a = int'(a32) + i;
                  ref_mem[d][a] = expw[8*(a % 4) +: 8];
               end
            end else if (!err) begin
               m = lane_mask(a32, 3'(sz));
               expw = 32'd0;
               for (int i = 0; i < (1 << sz); i++) begin
                  a = int'(a32) + i;
                  expw[8*(a % 4) +: 8] = ref_mem[d][a];
               end
               check("rand rdata", rd & m, expw);
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
